// File: rtl/register_tree_pq_pkg.sv
// Shared types and sizing helpers for the register-tree priority queue.
package register_tree_pq_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_SETTLE
   } state_e;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_ENQ,
      OP_DEQ,
      OP_REP
   } op_e;

   // Number of tree levels needed to hold queue_size entries.
   function automatic int tree_depth(input int queue_size);
      return $clog2(queue_size + 1);
   endfunction

   // Nodes in a complete binary tree of tree_depth(queue_size) levels.
   function automatic int node_count(input int queue_size);
      return (1 << tree_depth(queue_size)) - 1;
   endfunction

   // Level of a node in the implicit array layout (root is level 0).
   function automatic int node_level(input int idx);
      return $clog2(idx + 2) - 1;
   endfunction

endpackage

// File: rtl/register_tree_cas_node.sv
// Combinational compare-swap of one parent against its two children.
// Nodes carry {valid, key}; an invalid node ranks below every valid key.
module register_tree_cas_node #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_HEAP   = 1
) (
   input  logic                  i_p_valid,
   input  logic [DATA_WIDTH-1:0] i_p_key,
   input  logic                  i_l_valid,
   input  logic [DATA_WIDTH-1:0] i_l_key,
   input  logic                  i_r_valid,
   input  logic [DATA_WIDTH-1:0] i_r_key,
   output logic                  o_p_valid,
   output logic [DATA_WIDTH-1:0] o_p_key,
   output logic                  o_l_valid,
   output logic [DATA_WIDTH-1:0] o_l_key,
   output logic                  o_r_valid,
   output logic [DATA_WIDTH-1:0] o_r_key
);

   // True when node a strictly outranks node b in the configured order.
   function automatic logic outranks(input logic a_valid, input logic [DATA_WIDTH-1:0] a_key,
                                     input logic b_valid, input logic [DATA_WIDTH-1:0] b_key);
      if (!a_valid) return 1'b0;
      if (!b_valid) return 1'b1;
      if (MAX_HEAP != 0) return (a_key > b_key);
      return (a_key < b_key);
   endfunction

   logic right_better;

   // Pick the better child (ties go left) and swap it up only if it strictly wins.
   always_comb begin
      o_p_valid = i_p_valid;
      o_p_key   = i_p_key;
      o_l_valid = i_l_valid;
      o_l_key   = i_l_key;
      o_r_valid = i_r_valid;
      o_r_key   = i_r_key;
      right_better = outranks(i_r_valid, i_r_key, i_l_valid, i_l_key);
      if (right_better) begin
         if (outranks(i_r_valid, i_r_key, i_p_valid, i_p_key)) begin
            o_p_valid = i_r_valid;
            o_p_key   = i_r_key;
            o_r_valid = i_p_valid;
            o_r_key   = i_p_key;
         end
      end else begin
         if (outranks(i_l_valid, i_l_key, i_p_valid, i_p_key)) begin
            o_p_valid = i_l_valid;
            o_p_key   = i_l_key;
            o_l_valid = i_p_valid;
            o_l_key   = i_p_key;
         end
      end
   end

endmodule

// File: rtl/register_tree_pq.sv
// Register-tree priority queue. Each operation edits the tree directly, then
// the queue stays busy for TREE_DEPTH cycles while even/odd compare-swap
// passes restore heap order, so the root is always correct when ready.
module register_tree_pq
   import register_tree_pq_pkg::*;
#(
   parameter int QUEUE_SIZE = 7,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_HEAP   = 1
) (
   input  logic                             i_CLK,
   input  logic                             i_RST,
   input  logic                             i_wrt,
   input  logic                             i_read,
   input  logic [DATA_WIDTH-1:0]            i_data,
   output logic                             o_ready,
   output logic                             o_valid,
   output logic [DATA_WIDTH-1:0]            o_data,
   output logic                             o_full,
   output logic                             o_empty,
   output logic [$clog2(QUEUE_SIZE+1)-1:0]  o_count,
   output logic                             o_err
);

   localparam int TREE_DEPTH  = tree_depth(QUEUE_SIZE);
   localparam int NODES       = node_count(QUEUE_SIZE);
   localparam int NUM_PARENTS = (NODES - 1) / 2;
   localparam int CNT_W       = $clog2(QUEUE_SIZE + 1);
   localparam int SETTLE_W    = $clog2(TREE_DEPTH + 1);
   localparam int IDX_W       = $clog2(NODES);

   state_e                              state_q, state_d;
   logic [SETTLE_W-1:0]                 settle_q, settle_d;
   logic [CNT_W-1:0]                    count_q, count_d;
   logic                                err_q, err_d;
   logic [NODES-1:0]                    valid_q, valid_d;
   logic [NODES-1:0][DATA_WIDTH-1:0]    key_q, key_d;

   // Tree after the even-level pass, and after the following odd-level pass.
   logic [NODES-1:0]                    ev_valid, od_valid;
   logic [NODES-1:0][DATA_WIDTH-1:0]    ev_key, od_key;

   op_e              op;
   logic [IDX_W-1:0] free_idx;
   logic             is_full, is_empty;

   assign is_full  = (count_q == CNT_W'(QUEUE_SIZE));
   assign is_empty = (count_q == '0);

   // ---------------------------------------------------------------------
   // Even-level pass: parents at levels 0, 2, ... compare against children.
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PARENTS; gi++) begin : g_even
         if (node_level(gi) % 2 == 0) begin : g_cas
            register_tree_cas_node #(
               .DATA_WIDTH (DATA_WIDTH),
               .MAX_HEAP   (MAX_HEAP)
            ) u_cas (
               .i_p_valid (valid_q[gi]),
               .i_p_key   (key_q[gi]),
               .i_l_valid (valid_q[2*gi+1]),
               .i_l_key   (key_q[2*gi+1]),
               .i_r_valid (valid_q[2*gi+2]),
               .i_r_key   (key_q[2*gi+2]),
               .o_p_valid (ev_valid[gi]),
               .o_p_key   (ev_key[gi]),
               .o_l_valid (ev_valid[2*gi+1]),
               .o_l_key   (ev_key[2*gi+1]),
               .o_r_valid (ev_valid[2*gi+2]),
               .o_r_key   (ev_key[2*gi+2])
            );
         end
      end

      // Nodes not touched by any even-level triple pass straight through.
      for (gi = 0; gi < NODES; gi++) begin : g_even_thru
         if (!((node_level(gi) % 2 == 0 && gi < NUM_PARENTS) || (node_level(gi) % 2 == 1))) begin : g_thru
            assign ev_valid[gi] = valid_q[gi];
            assign ev_key[gi]   = key_q[gi];
         end
      end

      // ------------------------------------------------------------------
      // Odd-level pass on the even-pass result.
      // ------------------------------------------------------------------
      for (gi = 0; gi < NUM_PARENTS; gi++) begin : g_odd
         if (node_level(gi) % 2 == 1) begin : g_cas
            register_tree_cas_node #(
               .DATA_WIDTH (DATA_WIDTH),
               .MAX_HEAP   (MAX_HEAP)
            ) u_cas (
               .i_p_valid (ev_valid[gi]),
               .i_p_key   (ev_key[gi]),
               .i_l_valid (ev_valid[2*gi+1]),
               .i_l_key   (ev_key[2*gi+1]),
               .i_r_valid (ev_valid[2*gi+2]),
               .i_r_key   (ev_key[2*gi+2]),
               .o_p_valid (od_valid[gi]),
               .o_p_key   (od_key[gi]),
               .o_l_valid (od_valid[2*gi+1]),
               .o_l_key   (od_key[2*gi+1]),
               .o_r_valid (od_valid[2*gi+2]),
               .o_r_key   (od_key[2*gi+2])
            );
         end
      end

      // Root and any node outside an odd-level triple pass straight through.
      for (gi = 0; gi < NODES; gi++) begin : g_odd_thru
         if (!((node_level(gi) % 2 == 1 && gi < NUM_PARENTS) || (node_level(gi) % 2 == 0 && gi > 0))) begin : g_thru
            assign od_valid[gi] = ev_valid[gi];
            assign od_key[gi]   = ev_key[gi];
         end
      end
   endgenerate

   // Lowest-index empty slot among the writable nodes.
   always_comb begin
      free_idx = '0;
      for (int n = QUEUE_SIZE - 1; n >= 0; n--) begin
         if (!valid_q[n]) free_idx = IDX_W'(n);
      end
   end

   // Decode the request; it only counts while the queue is idle.
   always_comb begin
      op = OP_NONE;
      if (state_q == ST_IDLE) begin
         case ({i_wrt, i_read})
            2'b10:   op = OP_ENQ;
            2'b01:   op = OP_DEQ;
            2'b11:   op = OP_REP;
            default: op = OP_NONE;
         endcase
      end
   end

   // Next-state: apply the operation in IDLE, run compare-swap passes in SETTLE.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      count_d  = count_q;
      err_d    = 1'b0;
      valid_d  = valid_q;
      key_d    = key_q;
      if (state_q == ST_IDLE) begin
         if (op != OP_NONE) begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_W'(TREE_DEPTH);
         end
         case (op)
            OP_ENQ: begin
               if (is_full) begin
                  err_d = 1'b1;
               end else begin
                  valid_d[free_idx] = 1'b1;
                  key_d[free_idx]   = i_data;
                  count_d           = count_q + CNT_W'(1);
               end
            end
            OP_DEQ: begin
               if (is_empty) begin
                  err_d = 1'b1;
               end else begin
                  valid_d[0] = 1'b0;
                  key_d[0]   = '0;
                  count_d    = count_q - CNT_W'(1);
               end
            end
            OP_REP: begin
               // An empty tree has every node invalid, so the root is also the free slot.
               valid_d[0] = 1'b1;
               key_d[0]   = i_data;
               if (is_empty) count_d = CNT_W'(1);
            end
            OP_NONE: begin
            end
         endcase
      end else begin
         valid_d  = od_valid;
         key_d    = od_key;
         settle_d = settle_q - SETTLE_W'(1);
         if (settle_q == SETTLE_W'(1)) state_d = ST_IDLE;
      end
   end

   // State and tree registers with synchronous reset.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q  <= ST_IDLE;
         settle_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
         valid_q  <= '0;
         key_q    <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         count_q  <= count_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
         key_q    <= key_d;
      end
   end

   assign o_ready = (state_q == ST_IDLE);
   assign o_valid = o_ready && !is_empty;
   assign o_data  = o_valid ? key_q[0] : '0;
   assign o_full  = is_full;
   assign o_empty = is_empty;
   assign o_count = count_q;
   assign o_err   = err_q;

endmodule

// File: tb/tb_register_tree_pq.sv
// Randomised + directed bench for register_tree_pq against a queue-based model.
// Instance a is a max-queue, instance b a min-queue; both hold 7 entries of 8 bits.
module tb_register_tree_pq;

   localparam int QS    = 7;
   localparam int DW    = 8;
   localparam int DEPTH = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          wrt_a, rd_a, wrt_b, rd_b;
   logic [DW-1:0] din_a, din_b;
   logic          ready_a, valid_a, full_a, empty_a, err_a;
   logic          ready_b, valid_b, full_b, empty_b, err_b;
   logic [DW-1:0] data_a, data_b;
   logic [2:0]    count_a, count_b;

   int n_checks = 0;
   int n_errors = 0;
   int qa[$];
   int qb[$];

   register_tree_pq #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .MAX_HEAP(1)) dut_a (
      .i_CLK(clk), .i_RST(rst), .i_wrt(wrt_a), .i_read(rd_a), .i_data(din_a),
      .o_ready(ready_a), .o_valid(valid_a), .o_data(data_a), .o_full(full_a),
      .o_empty(empty_a), .o_count(count_a), .o_err(err_a)
   );

   register_tree_pq #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .MAX_HEAP(0)) dut_b (
      .i_CLK(clk), .i_RST(rst), .i_wrt(wrt_b), .i_read(rd_b), .i_data(din_b),
      .o_ready(ready_b), .o_valid(valid_b), .o_data(data_b), .o_full(full_b),
      .o_empty(empty_b), .o_count(count_b), .o_err(err_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---- reference model: an unordered bag; the root is its max (a) or min (b)
   function automatic int model_size(input bit sel);
      return sel ? qb.size() : qa.size();
   endfunction

   function automatic int model_root(input bit sel);
      int r;
      if (sel) begin
         if (qb.size() == 0) return 0;
         r = qb[0];
         foreach (qb[i]) if (qb[i] < r) r = qb[i];
      end else begin
         if (qa.size() == 0) return 0;
         r = qa[0];
         foreach (qa[i]) if (qa[i] > r) r = qa[i];
      end
      return r;
   endfunction

   task automatic model_push(input bit sel, input int d);
      if (sel) qb.push_back(d);
      else     qa.push_back(d);
   endtask

   task automatic model_pop_root(input bit sel);
      int r;
      bit done;
      r = model_root(sel);
      done = 1'b0;
      if (sel) begin
         for (int i = 0; i < qb.size() && !done; i++)
            if (qb[i] == r) begin qb.delete(i); done = 1'b1; end
      end else begin
         for (int i = 0; i < qa.size() && !done; i++)
            if (qa[i] == r) begin qa.delete(i); done = 1'b1; end
      end
   endtask

   // ---- pin access
   task automatic drive(input bit sel, input bit w, input bit r, input logic [DW-1:0] d);
      if (sel) begin wrt_b = w; rd_b = r; din_b = d; end
      else     begin wrt_a = w; rd_a = r; din_a = d; end
   endtask

   task automatic get_outs(input bit sel, output int rdy, output int vld, output int ful,
                           output int emp, output int err, output int cnt, output int dat);
      if (sel) begin
         rdy = int'(ready_b); vld = int'(valid_b); ful = int'(full_b); emp = int'(empty_b);
         err = int'(err_b); cnt = int'(count_b); dat = int'(data_b);
      end else begin
         rdy = int'(ready_a); vld = int'(valid_a); ful = int'(full_a); emp = int'(empty_a);
         err = int'(err_a); cnt = int'(count_a); dat = int'(data_a);
      end
   endtask

   // One operation: issue at an edge, check post-op flags, wait out the busy
   // window (optionally hammering the inputs), then check the settled root.
   task automatic do_op(input bit sel, input bit w, input bit r, input logic [DW-1:0] d, input bit poke);
      int n, lows, exp_n;
      bit rej, is_op;
      int rdy, vld, ful, emp, err, cnt, dat;
      string name;
      n     = model_size(sel);
      is_op = w | r;
      rej   = 1'b0;
      if (w && !r) begin
         name = "ENQ";
         if (n == QS) rej = 1'b1; else model_push(sel, int'(d));
      end else if (!w && r) begin
         name = "DEQ";
         if (n == 0) rej = 1'b1; else model_pop_root(sel);
      end else if (w && r) begin
         name = "REP";
         if (n > 0) model_pop_root(sel);
         model_push(sel, int'(d));
      end else begin
         name = "NOP";
      end
      exp_n = model_size(sel);

      drive(sel, w, r, d);
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'b0, '0);
      get_outs(sel, rdy, vld, ful, emp, err, cnt, dat);
      check_eq({name, "_ready_after_edge"}, rdy, is_op ? 0 : 1);
      check_eq({name, "_err_pulse"}, err, rej);
      check_eq({name, "_count_after_edge"}, cnt, exp_n);
      check_eq({name, "_full"}, ful, (exp_n == QS) ? 1 : 0);
      check_eq({name, "_empty"}, emp, (exp_n == 0) ? 1 : 0);

      if (is_op) begin
         lows = 1;
         while (rdy == 0 && lows <= 20) begin
            if (poke) drive(sel, 1'b1, ($urandom_range(0, 1) == 1), DW'($urandom_range(0, 255)));
            @(posedge clk); #1;
            drive(sel, 1'b0, 1'b0, '0);
            get_outs(sel, rdy, vld, ful, emp, err, cnt, dat);
            if (rdy == 0) lows++;
         end
         check_eq({name, "_busy_cycles"}, lows, DEPTH);
      end

      check_eq({name, "_err_cleared"}, err, 0);
      check_eq({name, "_valid"}, vld, (exp_n > 0) ? 1 : 0);
      check_eq({name, "_root"}, dat, model_root(sel));
      check_eq({name, "_count_settled"}, cnt, exp_n);
      $display("txn dut=%s op=%s in=%0d poke=%0d count=%0d root=%0d rejected=%0d",
               sel ? "min" : "max", name, d, poke, cnt, dat, rej);
   endtask

   task automatic check_reset_state(input bit sel, input string tag);
      int rdy, vld, ful, emp, err, cnt, dat;
      get_outs(sel, rdy, vld, ful, emp, err, cnt, dat);
      check_eq({tag, "_ready"}, rdy, 1);
      check_eq({tag, "_valid"}, vld, 0);
      check_eq({tag, "_data"}, dat, 0);
      check_eq({tag, "_full"}, ful, 0);
      check_eq({tag, "_empty"}, emp, 1);
      check_eq({tag, "_count"}, cnt, 0);
      check_eq({tag, "_err"}, err, 0);
      $display("txn dut=%s op=RESET count=%0d ready=%0d", sel ? "min" : "max", cnt, rdy);
   endtask

   initial begin
      bit sel, w, r, poke;
      int kind;
      logic [DW-1:0] d;

      rst = 1'b1;
      drive(0, 0, 0, '0);
      drive(1, 0, 0, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_state(0, "reset_a");
      check_reset_state(1, "reset_b");

      // max-queue: enqueue with a zero key, drain in order, underflow
      do_op(0, 1, 0, 8'd5, 0);
      do_op(0, 1, 0, 8'd0, 0);
      do_op(0, 1, 0, 8'd9, 0);
      do_op(0, 1, 0, 8'd3, 0);
      repeat (5) do_op(0, 0, 1, '0, 0);

      // fill, overflow, replace the root
      for (int k = 1; k <= 7; k++) do_op(0, 1, 0, DW'(k), 0);
      do_op(0, 1, 0, 8'd8, 0);
      do_op(0, 1, 1, 8'd4, 0);

      // min-queue ordering
      do_op(1, 1, 0, 8'd200, 0);
      do_op(1, 1, 0, 8'd17, 0);
      do_op(1, 1, 0, 8'd90, 0);
      do_op(1, 0, 1, '0, 0);

      // requests during the busy window are dropped silently
      do_op(0, 0, 1, '0, 1);
      do_op(1, 1, 0, 8'd33, 1);

      // reset in the middle of a settle
      drive(0, 1, 0, 8'd42);
      @(posedge clk); #1;
      drive(0, 0, 0, '0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      qa.delete();
      qb.delete();
      check_reset_state(0, "midsettle_reset_a");
      check_reset_state(1, "midsettle_reset_b");

      // randomised mix on both queues, with plenty of duplicate and zero keys
      for (int i = 0; i < 160; i++) begin
         sel  = ($urandom_range(0, 1) == 1);
         kind = $urandom_range(0, 9);
         w    = (kind <= 3) || (kind == 7) || (kind == 8);
         r    = (kind >= 4) && (kind <= 8);
         d    = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom_range(0, 255));
         poke = ($urandom_range(0, 3) == 0);
         do_op(sel, w, r, d, poke);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
